ring_counter: RTL and testbench

- One-hot ring counter: a single set bit rotates one position per clock across a WIDTH-bit register, giving a decoded WIDTH-phase sequencer.
- Intended as a phase or strobe generator driving one-of-N enables in downstream datapaths.
- Recovers by itself from any non-one-hot state.

---
 rtl/ring_counter.sv | 75 +++++++
 tb/tb_ring_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter.sv
// ring_counter: one-hot ring counter used as a WIDTH-phase strobe sequencer.
// A single set bit rotates one position per clk edge. Any state that is not
// exactly one-hot (all zeros or several bits set) is replaced by SEED on the
// next non-reset edge, so the ring always recovers by itself.
//
// Optional feature macro: RING_COUNTER_ERR_EN
//   When defined, an extra output 'err' follows q_out. It is a registered
//   one-cycle pulse raised on every edge that reloads SEED because the ring
//   was not one-hot. Reset clears it.
module ring_counter #(
    parameter int unsigned       WIDTH = 4,
    parameter logic [WIDTH-1:0]  SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit                DIR   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef RING_COUNTER_ERR_EN
    output logic [WIDTH-1:0] q_out,
    output logic             err
`else
    output logic [WIDTH-1:0] q_out
`endif
);

    localparam logic [WIDTH-1:0] ONE          = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam bit               SEED_ONE_HOT = (SEED != '0) && ((SEED & (SEED - ONE)) == '0);

    // Parameter legality is checked while the design elaborates.
    if ((WIDTH < 2) || (WIDTH > 64)) begin : g_width_chk
        $error("ring_counter: WIDTH must lie in 2..64");
    end

    if (!SEED_ONE_HOT) begin : g_seed_chk
        $error("ring_counter: SEED must have exactly one bit set");
    end

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next_rot;
    logic             one_hot;

    // One-hot test on the current register value: nonzero and a power of two.
    assign one_hot = (q_reg != '0) && ((q_reg & (q_reg - ONE)) == '0);

    // Rotation by one position in the configured direction.
    if (DIR == 1'b0) begin : g_rot_up
        assign q_next_rot = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
    end else begin : g_rot_dn
        assign q_next_rot = {q_reg[0], q_reg[WIDTH-1:1]};
    end

    // Ring register: reset and self-correction both load SEED, else rotate.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= SEED;
        end else if (!one_hot) begin
            q_reg <= SEED;
        end else begin
            q_reg <= q_next_rot;
        end
    end

    assign q_out = q_reg;

`ifdef RING_COUNTER_ERR_EN
    // Recovery flag: pulses on the same edge that reloads SEED after an illegal state.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= !one_hot;
        end
    end
`endif

endmodule

// File: tb/tb_ring_counter.sv
// tb_ring_counter: scoreboard bench for ring_counter. Four instances cover
// WIDTH=4 up, WIDTH=4 down, WIDTH=2 and WIDTH=8. The reference model tracks the
// index of the hot bit per instance with modular arithmetic; expected values
// are queued by the driver and popped by an independent monitor.
// Builds with or without RING_COUNTER_ERR_EN.
module tb_ring_counter;

    logic clk;
    logic rst;

    logic [3:0] q0;
    logic [3:0] q1;
    logic [1:0] q2;
    logic [7:0] q3;
`ifdef RING_COUNTER_ERR_EN
    logic       e0, e1, e2, e3;
`endif

    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR(1'b0)) u_w4_up (
        .clk(clk), .rst(rst),
`ifdef RING_COUNTER_ERR_EN
        .q_out(q0), .err(e0)
`else
        .q_out(q0)
`endif
    );

    ring_counter #(.WIDTH(4), .SEED(4'b0001), .DIR(1'b1)) u_w4_dn (
        .clk(clk), .rst(rst),
`ifdef RING_COUNTER_ERR_EN
        .q_out(q1), .err(e1)
`else
        .q_out(q1)
`endif
    );

    ring_counter #(.WIDTH(2), .SEED(2'b01), .DIR(1'b0)) u_w2 (
        .clk(clk), .rst(rst),
`ifdef RING_COUNTER_ERR_EN
        .q_out(q2), .err(e2)
`else
        .q_out(q2)
`endif
    );

    ring_counter #(.WIDTH(8), .SEED(8'h01), .DIR(1'b0)) u_w8 (
        .clk(clk), .rst(rst),
`ifdef RING_COUNTER_ERR_EN
        .q_out(q3), .err(e3)
`else
        .q_out(q3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][63:0] q;
        logic [3:0]       e;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position of the hot bit per instance.
    int wid [4] = '{4, 4, 2, 8};
    int dir [4] = '{0, 1, 0, 0};
    int pos [4] = '{0, 0, 0, 0};

    logic [3:0] inj_v0;
    logic [3:0] inj_v1;

    function automatic logic [3:0] bad4();
        logic [3:0] v;
        do begin
            v = 4'($urandom_range(0, 15));
        end while ($countones(v) == 1);
        return v;
    endfunction

    task automatic model_step(input bit r, input bit [1:0] inj);
        exp_t x;
        for (int k = 0; k < 4; k++) begin
            x.e[k] = 1'b0;
            if (r) begin
                pos[k] = 0;
            end else if ((k < 2) && inj[k]) begin
                pos[k] = 0;
                x.e[k] = 1'b1;
            end else if (dir[k] == 0) begin
                pos[k] = (pos[k] + 1) % wid[k];
            end else begin
                pos[k] = (pos[k] + wid[k] - 1) % wid[k];
            end
            x.q[k] = 64'd1 << pos[k];
        end
        sb.push_back(x);
    endtask

    // One clock of stimulus: drive rst, optionally corrupt the W4 rings,
    // optionally pulse rst entirely between edges, then queue the expectation.
    task automatic cycle(input bit r, input bit [1:0] inj, input bit pulse);
        @(negedge clk);
        rst = r;
        if (inj[0]) begin
            inj_v0 = bad4();
            force u_w4_up.q_reg = inj_v0;
        end
        if (inj[1]) begin
            inj_v1 = bad4();
            force u_w4_dn.q_reg = inj_v1;
        end
        #1;
        if (inj[0]) release u_w4_up.q_reg;
        if (inj[1]) release u_w4_dn.q_reg;
        if (pulse) begin
            rst = 1'b1;
            #1;
            rst = r;
        end
        model_step(r, inj);
    endtask

    task automatic cmp_q(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic cmp_e(input string name, input logic got, input logic want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%b want=%b t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: after each rising edge, pop the queued expectation and compare.
    always @(posedge clk) begin
        exp_t x;
        #1;
        if (sb.size() > 0) begin
            x = sb.pop_front();
            cmp_q("q_w4_up", 64'(q0), x.q[0]);
            cmp_q("q_w4_dn", 64'(q1), x.q[1]);
            cmp_q("q_w2",    64'(q2), x.q[2]);
            cmp_q("q_w8",    64'(q3), x.q[3]);
`ifdef RING_COUNTER_ERR_EN
            cmp_e("err_w4_up", e0, x.e[0]);
            cmp_e("err_w4_dn", e1, x.e[1]);
            cmp_e("err_w2",    e2, x.e[2]);
            cmp_e("err_w8",    e3, x.e[3]);
`endif
        end
    end

    initial begin
        int drain;
        rst    = 1'b1;
        inj_v0 = 4'b0000;
        inj_v1 = 4'b0000;

        // Reset hold: SEED on every edge.
        repeat (12) cycle(1'b1, 2'b00, 1'b0);

        // Free run through the wrap until the W4 up ring shows 0100 again.
        repeat (6) cycle(1'b0, 2'b00, 1'b0);

        // Reset mid-sequence, then a between-edge rst pulse that must do nothing.
        cycle(1'b1, 2'b00, 1'b0);
        cycle(1'b0, 2'b00, 1'b1);
        repeat (3) cycle(1'b0, 2'b00, 1'b0);

        // Forced illegal states followed by normal rotation.
        @(negedge clk);
        rst    = 1'b0;
        inj_v0 = 4'b0000;
        inj_v1 = 4'b1010;
        force u_w4_up.q_reg = inj_v0;
        force u_w4_dn.q_reg = inj_v1;
        #1;
        release u_w4_up.q_reg;
        release u_w4_dn.q_reg;
        model_step(1'b0, 2'b11);
        repeat (3) cycle(1'b0, 2'b00, 1'b0);

        @(negedge clk);
        inj_v0 = 4'b1010;
        inj_v1 = 4'b0000;
        force u_w4_up.q_reg = inj_v0;
        force u_w4_dn.q_reg = inj_v1;
        #1;
        release u_w4_up.q_reg;
        release u_w4_dn.q_reg;
        model_step(1'b0, 2'b11);
        repeat (4) cycle(1'b0, 2'b00, 1'b0);

        // Randomized mix of reset, corruption and free running.
        for (int i = 0; i < 400; i++) begin
            bit         r;
            bit [1:0]   inj;
            r      = ($urandom_range(0, 9) == 0);
            inj[0] = ($urandom_range(0, 14) == 0);
            inj[1] = ($urandom_range(0, 14) == 0);
            cycle(r, inj, ($urandom_range(0, 7) == 0));
        end

        drain = 0;
        while ((sb.size() > 0) && (drain < 5)) begin
            @(negedge clk);
            drain++;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
